// File: rtl/alu_pkg.sv
// Shared opcode map, FSM state encoding and divide special-case constants for the multicycle ALU.
package alu_pkg;

    // Upper bound on WIDTH for the width-parametric constant helpers below.
    localparam int ALU_MAX_W = 64;

    localparam logic [4:0] OP_ADD   = 5'b00000;
    localparam logic [4:0] OP_SUB   = 5'b00001;
    localparam logic [4:0] OP_AND   = 5'b00010;
    localparam logic [4:0] OP_OR    = 5'b00011;
    localparam logic [4:0] OP_XOR   = 5'b00100;
    localparam logic [4:0] OP_LUI   = 5'b00101;
    localparam logic [4:0] OP_SRL   = 5'b00110;
    localparam logic [4:0] OP_SLL   = 5'b00111;
    localparam logic [4:0] OP_SRA   = 5'b01000;
    localparam logic [4:0] OP_SLT   = 5'b01001;
    localparam logic [4:0] OP_SLTU  = 5'b01010;
    localparam logic [4:0] OP_MUL   = 5'b10000;
    localparam logic [4:0] OP_MULH  = 5'b10001;
    localparam logic [4:0] OP_MULHU = 5'b10011;
    localparam logic [4:0] OP_DIV   = 5'b10100;
    localparam logic [4:0] OP_DIVU  = 5'b10101;
    localparam logic [4:0] OP_REM   = 5'b10110;
    localparam logic [4:0] OP_REMU  = 5'b10111;

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} alu_state_e;

    function automatic logic [ALU_MAX_W-1:0] div0_quot(input int w);
        logic [ALU_MAX_W-1:0] ones;
        ones = '1;
        return ones >> (ALU_MAX_W - w);
    endfunction

    function automatic logic [ALU_MAX_W-1:0] most_neg(input int w);
        return ALU_MAX_W'(1) << (w - 1);
    endfunction

    function automatic logic [ALU_MAX_W-1:0] div_ovf_rem(input int w);
        return ALU_MAX_W'(0) & div0_quot(w);
    endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative multiply/divide engine: shift-add multiply and restoring divide on magnitudes,
// one step per cycle, with the sign correction applied while in FIX.
module alu_muldiv_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    input  logic [4:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             fix_o,
    output logic [WIDTH-1:0] result_o
);
    localparam int CW = $clog2(WIDTH);

    alu_state_e         state_q;
    logic [CW-1:0]      cnt_q;
    logic [2*WIDTH-1:0] acc_q, acc_cur, acc_nxt, prod;
    logic [WIDTH-1:0]   opnd_q, opnd_cur, ma, mb, quo, rem;
    logic [4:0]         op_q;
    logic               nq_q, nr_q;
    logic               signed_op, sa, sb, div_cur;
    logic [WIDTH:0]     mul_sum, div_trial, div_diff;

    assign signed_op = (op_i == OP_MULH) || (op_i == OP_DIV) || (op_i == OP_REM);
    assign sa = signed_op & a_i[WIDTH-1];
    assign sb = signed_op & b_i[WIDTH-1];
    assign ma = sa ? -a_i : a_i;
    assign mb = sb ? -b_i : b_i;

    // The accept cycle already performs iteration 0 straight from the operands.
    assign acc_cur  = start_i ? {{WIDTH{1'b0}}, ma} : acc_q;
    assign opnd_cur = start_i ? mb : opnd_q;
    assign div_cur  = start_i ? op_i[2] : op_q[2];

    always_comb begin
        mul_sum   = {1'b0, acc_cur[2*WIDTH-1:WIDTH]} + (acc_cur[0] ? {1'b0, opnd_cur} : '0);
        div_trial = {acc_cur[2*WIDTH-1:WIDTH], acc_cur[WIDTH-1]};
        div_diff  = div_trial - {1'b0, opnd_cur};
        if (div_cur)
            acc_nxt = {(div_diff[WIDTH] ? div_trial[WIDTH-1:0] : div_diff[WIDTH-1:0]),
                       acc_cur[WIDTH-2:0], ~div_diff[WIDTH]};
        else
            acc_nxt = {mul_sum, acc_cur[WIDTH-1:1]};
    end

    always_comb begin
        prod = nq_q ? -acc_q : acc_q;
        quo  = nq_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem  = nr_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
        if (op_q[2])
            result_o = op_q[1] ? rem : quo;
        else
            result_o = (op_q == OP_MUL) ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            opnd_q  <= '0;
            op_q    <= '0;
            nq_q    <= 1'b0;
            nr_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (start_i) begin
                    acc_q   <= acc_nxt;
                    opnd_q  <= mb;
                    op_q    <= op_i;
                    nq_q    <= sa ^ sb;
                    nr_q    <= sa;
                    cnt_q   <= CW'(1);
                    state_q <= op_i[2] ? DIV : MUL;
                end
                MUL, DIV: begin
                    acc_q <= acc_nxt;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CW'(WIDTH - 1))
                        state_q <= FIX;
                end
                FIX: begin
                    cnt_q   <= '0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy_o = (state_q != IDLE);
    assign fix_o  = (state_q == FIX);

endmodule

// File: rtl/alu_multicycle.sv
// Registered ALU with start/busy/done handshake; single-cycle ops here, mul/div in alu_muldiv_iter.
// Define ALU_FAST_MUL_EN to make MUL/MULH/MULHU single-cycle with a combinational multiplier.
module alu_multicycle
    import alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Start_i,
    input  logic [4:0]       ALU_Operation_i,
    input  logic [WIDTH-1:0] A_i,
    input  logic [WIDTH-1:0] B_i,
    output logic             Busy_o,
    output logic             Done_o,
    output logic             Zero_o,
    output logic [WIDTH-1:0] ALU_Result_o
);
    logic               accept, iter_op, is_div_op, b_zero, ovf, div_special;
    logic               eng_fix;
    logic [WIDTH-1:0]   eng_res, single_res, res_q;
    logic [SHAMT_W-1:0] shamt;
    logic               done_q, zero_q;

    assign shamt       = B_i[SHAMT_W-1:0];
    assign accept      = Start_i && !Busy_o;
    assign is_div_op   = (ALU_Operation_i[4:2] == 3'b101);
    assign b_zero      = (B_i == '0);
    assign ovf         = is_div_op && !ALU_Operation_i[0] &&
                         (A_i == WIDTH'(most_neg(WIDTH))) && (B_i == '1);
    assign div_special = is_div_op && (b_zero || ovf);

`ifdef ALU_FAST_MUL_EN
    logic [2*WIDTH-1:0] prod_u;
    logic [WIDTH-1:0]   mulh;
    assign prod_u  = {{WIDTH{1'b0}}, A_i} * {{WIDTH{1'b0}}, B_i};
    // Signed high half recovered from the unsigned product.
    assign mulh    = prod_u[2*WIDTH-1:WIDTH] - (A_i[WIDTH-1] ? B_i : '0) - (B_i[WIDTH-1] ? A_i : '0);
    assign iter_op = is_div_op && !div_special;
`else
    logic is_mul_op;
    assign is_mul_op = (ALU_Operation_i == OP_MUL) || (ALU_Operation_i == OP_MULH) ||
                       (ALU_Operation_i == OP_MULHU);
    assign iter_op   = (is_div_op && !div_special) || is_mul_op;
`endif

    always_comb begin
        single_res = '0;
        case (ALU_Operation_i)
            OP_ADD:  single_res = A_i + B_i;
            OP_SUB:  single_res = A_i - B_i;
            OP_AND:  single_res = A_i & B_i;
            OP_OR:   single_res = A_i | B_i;
            OP_XOR:  single_res = A_i ^ B_i;
            OP_LUI:  single_res = B_i << 12;
            OP_SRL:  single_res = A_i >> shamt;
            OP_SLL:  single_res = A_i << shamt;
            OP_SRA:  single_res = $signed(A_i) >>> shamt;
            OP_SLT:  single_res = {{(WIDTH-1){1'b0}}, ($signed(A_i) < $signed(B_i))};
            OP_SLTU: single_res = {{(WIDTH-1){1'b0}}, (A_i < B_i)};
            OP_DIV, OP_DIVU: single_res = b_zero ? WIDTH'(div0_quot(WIDTH)) : A_i;
            OP_REM, OP_REMU: single_res = b_zero ? A_i : WIDTH'(div_ovf_rem(WIDTH));
`ifdef ALU_FAST_MUL_EN
            OP_MUL:   single_res = prod_u[WIDTH-1:0];
            OP_MULH:  single_res = mulh;
            OP_MULHU: single_res = prod_u[2*WIDTH-1:WIDTH];
`endif
            default: single_res = '0;
        endcase
    end

    alu_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
        .clk      (clk),
        .reset    (reset),
        .start_i  (accept && iter_op),
        .op_i     (ALU_Operation_i),
        .a_i      (A_i),
        .b_i      (B_i),
        .busy_o   (Busy_o),
        .fix_o    (eng_fix),
        .result_o (eng_res)
    );

    // Busy covers FIX, so an engine result never collides with a single-cycle accept.
    always_ff @(posedge clk) begin
        if (reset) begin
            done_q <= 1'b0;
            res_q  <= '0;
            zero_q <= 1'b1;
        end else begin
            done_q <= 1'b0;
            if (eng_fix) begin
                res_q  <= eng_res;
                zero_q <= (eng_res == '0);
                done_q <= 1'b1;
            end else if (accept && !iter_op) begin
                res_q  <= single_res;
                zero_q <= (single_res == '0);
                done_q <= 1'b1;
            end
        end
    end

    assign Done_o       = done_q;
    assign Zero_o       = zero_q;
    assign ALU_Result_o = res_q;

endmodule
